// File: rtl/cam_alloc_pkg.sv
// Shared types and constants for the CAM allocation controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cam_alloc_pkg;

    // Controller states: accept, search CAM, write CAM, present response.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Request opcode carried on req_op.
    localparam logic OP_INS = 1'b0;
    localparam logic OP_DEL = 1'b1;

    // Free CAM entries always hold the all-zero key; wide enough for any
    // key width in use and cast down at the point of comparison.
    localparam logic [63:0] NULL_KEY = '0;

endpackage

// File: rtl/cam_alloc_if.sv
// Request/response handshake plus CAM write/search port bundle.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready and rsp_valid/rsp_ready handshakes.
// Ports: master = client + CAM side, slave = cam_alloc controller.
interface cam_alloc_if #(
    parameter int DATA  = 16,
    parameter int DEPTH = 64
);
    localparam int ADDR = $clog2(DEPTH);

    // client request
    logic            req_valid;
    logic            req_ready;
    logic            req_op;
    logic [DATA-1:0] req_key;
    logic [ADDR-1:0] req_idx;
    // client response
    logic            rsp_valid;
    logic            rsp_ready;
    logic [ADDR-1:0] rsp_idx;
    logic            rsp_hit;
    logic            rsp_evict;
    logic            rsp_err;
    // CAM write port (active-low enable)
    logic            cam_we_;
    logic [DATA-1:0] cam_wm;
    logic [DATA-1:0] cam_wd;
    logic [ADDR-1:0] cam_waddr;
    // CAM search port (active-low enable)
    logic            cam_re_;
    logic [DATA-1:0] cam_rm;
    logic [DATA-1:0] cam_rd;
    logic            cam_match;
    logic [ADDR-1:0] cam_raddr;

    modport master (
        output req_valid, req_op, req_key, req_idx, rsp_ready,
        output cam_match, cam_raddr,
        input  req_ready, rsp_valid, rsp_idx, rsp_hit, rsp_evict, rsp_err,
        input  cam_we_, cam_wm, cam_wd, cam_waddr, cam_re_, cam_rm, cam_rd
    );

    modport slave (
        input  req_valid, req_op, req_key, req_idx, rsp_ready,
        input  cam_match, cam_raddr,
        output req_ready, rsp_valid, rsp_idx, rsp_hit, rsp_evict, rsp_err,
        output cam_we_, cam_wm, cam_wd, cam_waddr, cam_re_, cam_rm, cam_rd
    );

endinterface

// File: rtl/cam_alloc_pri_enc.sv
// Priority encoder: index of the lowest set bit of req_vec.
// Latency: combinational.
// Backpressure: none.
// Ports: req_vec in (DEPTH), any_o out (some bit set), idx_o out (lowest set index, 0 if none).
module cam_alloc_pri_enc #(
    parameter int DEPTH = 64
) (
    input  logic [DEPTH-1:0]         req_vec,
    output logic                     any_o,
    output logic [$clog2(DEPTH)-1:0] idx_o
);
    localparam int ADDR = $clog2(DEPTH);

    always_comb begin
        any_o = |req_vec;
        idx_o = '0;
        // Scan from the top so the last assignment is the lowest set bit.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                idx_o = ADDR'(i);
            end
        end
    end

endmodule

// File: rtl/cam_alloc.sv
// CAM allocation controller: insert/delete requests become CAM searches and writes.
// Latency: accept->rsp_valid is 1 (null insert), 2 (insert hit, delete), 3 (insert miss) cycles.
// Backpressure: one request in flight; req_ready only in IDLE; response held until rsp_ready.
// Ports: clk, reset_ (async active-low), bus (slave side of cam_alloc_if),
//        valid_vec (per-entry valid bits), count (popcount of valid_vec).
module cam_alloc
    import cam_alloc_pkg::*;
#(
    parameter int DATA  = 16,
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   reset_,
    cam_alloc_if.slave             bus,
    output logic [DEPTH-1:0]       valid_vec,
    output logic [$clog2(DEPTH):0] count
);
    localparam int ADDR  = $clog2(DEPTH);
    localparam int CNT_W = ADDR + 1;

    state_e             state_q,  state_d;
    logic               op_q,     op_d;
    logic [DATA-1:0]    key_q,    key_d;
    logic [ADDR-1:0]    idx_q,    idx_d;
    logic               hit_q,    hit_d;
    logic               evict_q,  evict_d;
    logic               err_q,    err_d;
    logic [DEPTH-1:0]   valid_q,  valid_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic [ADDR-1:0]    vptr_q,   vptr_d;

    logic               free_any;
    logic [ADDR-1:0]    free_idx;
    logic               req_null;

    // Output-process intermediates, fanned out to the interface below.
    logic               req_ready_o;
    logic               rsp_valid_o;
    logic               cam_we_l;
    logic               cam_re_l;
    logic [DATA-1:0]    cam_wd_o;
    logic [DATA-1:0]    cam_rd_o;
    logic [ADDR-1:0]    cam_waddr_o;

    // Lowest free entry, used when a lookup misses and the table has room.
    cam_alloc_pri_enc #(
        .DEPTH (DEPTH)
    ) u_pri_enc (
        .req_vec (~valid_q),
        .any_o   (free_any),
        .idx_o   (free_idx)
    );

    assign req_null = (bus.req_key == DATA'(NULL_KEY));

    // State register and datapath flops.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= IDLE;
            op_q    <= OP_INS;
            key_q   <= '0;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            evict_q <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= '0;
            count_q <= '0;
            vptr_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
            evict_q <= evict_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            count_q <= count_d;
            vptr_q  <= vptr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req_op == OP_DEL) begin
                        state_d = WRITE;
                    end else if (req_null) begin
                        state_d = RESP;
                    end else begin
                        state_d = LOOKUP;
                    end
                end
            end
            LOOKUP:  state_d = bus.cam_match ? RESP : WRITE;
            WRITE:   state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values.
    always_comb begin
        op_d    = op_q;
        key_d   = key_q;
        idx_d   = idx_q;
        hit_d   = hit_q;
        evict_d = evict_q;
        err_d   = err_q;
        valid_d = valid_q;
        count_d = count_q;
        vptr_d  = vptr_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    key_d   = bus.req_key;
                    // Inserts get their index in LOOKUP; start from 0 so a
                    // rejected null insert reports a defined index.
                    idx_d   = (bus.req_op == OP_DEL) ? bus.req_idx : '0;
                    hit_d   = 1'b0;
                    evict_d = 1'b0;
                    err_d   = (bus.req_op == OP_INS) && req_null;
                end
            end
            LOOKUP: begin
                if (bus.cam_match) begin
                    // Key already resident: report its slot, no write.
                    hit_d = 1'b1;
                    idx_d = bus.cam_raddr;
                end else if (free_any) begin
                    idx_d = free_idx;
                end else begin
                    // Table full: overwrite the round-robin victim.
                    idx_d   = vptr_q;
                    evict_d = 1'b1;
                    vptr_d  = (vptr_q == ADDR'(DEPTH - 1)) ? '0 : vptr_q + ADDR'(1);
                end
            end
            WRITE: begin
                if (op_q == OP_INS) begin
                    valid_d[idx_q] = 1'b1;
                    // An eviction reuses a valid slot, so count only grows
                    // when a free slot is consumed.
                    if (!valid_q[idx_q]) begin
                        count_d = count_q + CNT_W'(1);
                    end
                end else begin
                    hit_d          = valid_q[idx_q];
                    valid_d[idx_q] = 1'b0;
                    if (valid_q[idx_q]) begin
                        count_d = count_q - CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from state; disabled CAM buses are forced to 0.
    always_comb begin
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        cam_we_l    = 1'b1;
        cam_re_l    = 1'b1;
        cam_wd_o    = '0;
        cam_rd_o    = '0;
        cam_waddr_o = '0;
        unique case (state_q)
            IDLE: req_ready_o = 1'b1;
            LOOKUP: begin
                cam_re_l = 1'b0;
                cam_rd_o = key_q;
            end
            WRITE: begin
                cam_we_l    = 1'b0;
                cam_waddr_o = idx_q;
                // Deletes write the null key so free slots never match.
                cam_wd_o    = (op_q == OP_INS) ? key_q : '0;
            end
            RESP: rsp_valid_o = 1'b1;
            default: ;
        endcase
    end

    assign bus.req_ready = req_ready_o;
    assign bus.rsp_valid = rsp_valid_o;
    assign bus.rsp_idx   = idx_q;
    assign bus.rsp_hit   = hit_q;
    assign bus.rsp_evict = evict_q;
    assign bus.rsp_err   = err_q;
    assign bus.cam_we_   = cam_we_l;
    assign bus.cam_wm    = '0;
    assign bus.cam_wd    = cam_wd_o;
    assign bus.cam_waddr = cam_waddr_o;
    assign bus.cam_re_   = cam_re_l;
    assign bus.cam_rm    = '0;
    assign bus.cam_rd    = cam_rd_o;

    assign valid_vec = valid_q;
    assign count     = count_q;

endmodule

// File: tb/tb_cam_alloc.sv
// Bench for cam_alloc with a behavioural CAM attached to its ports.
// Latency: n/a.
// Backpressure: response held for a chosen number of cycles before rsp_ready.
module tb_cam_alloc;
    localparam int DATA  = 16;
    localparam int DEPTH = 64;

    logic             clk;
    logic             reset_;
    logic [DEPTH-1:0] valid_vec;
    logic [6:0]       count;

    cam_alloc_if #(.DATA(DATA), .DEPTH(DEPTH)) bus ();

    cam_alloc #(.DATA(DATA), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_    (reset_),
        .bus       (bus),
        .valid_vec (valid_vec),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural CAM: reset shared with the controller, mask bit 1 = ignore.
    logic [DATA-1:0] cam_mem [DEPTH];
    always @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < DEPTH; i++) cam_mem[i] <= '0;
        end else if (!bus.cam_we_) begin
            cam_mem[bus.cam_waddr] <= (cam_mem[bus.cam_waddr] & bus.cam_wm) | (bus.cam_wd & ~bus.cam_wm);
        end
    end
    always_comb begin
        bus.cam_match = 1'b0;
        bus.cam_raddr = '0;
        if (!bus.cam_re_) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (((cam_mem[i] ^ bus.cam_rd) & ~bus.cam_rm) == '0) begin
                    bus.cam_match = 1'b1;
                    bus.cam_raddr = 6'(i);
                end
            end
        end
    end

    // Cycles with each CAM port enabled.
    int wr_cnt = 0;
    int rd_cnt = 0;
    always @(negedge clk) begin
        if (!bus.cam_we_) wr_cnt++;
        if (!bus.cam_re_) rd_cnt++;
    end

    // Reference model: what the table should contain.
    logic [DATA-1:0]  m_key [DEPTH];
    logic [DEPTH-1:0] m_vld;
    int               m_vptr;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_key[i] = '0;
        m_vld  = '0;
        m_vptr = 0;
    endtask

    function automatic bit in_model(input logic [DATA-1:0] k);
        for (int i = 0; i < DEPTH; i++) if (m_vld[i] && m_key[i] == k) return 1'b1;
        return 1'b0;
    endfunction

    task automatic fresh_key(output logic [DATA-1:0] k);
        do k = 16'($urandom_range(1, 65535)); while (in_model(k) || k == 16'hBEEF);
    endtask

    // Issue one request, check it against the model, release after `hold` cycles.
    task automatic do_req(input logic op, input logic [DATA-1:0] key, input logic [5:0] idx,
                          input int hold, output logic [5:0] o_idx, output logic o_hit,
                          output logic o_evict, output logic o_err);
        logic [5:0] e_idx;
        logic e_hit, e_evict, e_err;
        int e_lat, e_wr, e_rd, lat, wr0, rd0, found, free;
        e_idx = '0; e_hit = 0; e_evict = 0; e_err = 0; e_wr = 0; e_rd = 0; e_lat = 2;
        if (op == 1'b0) begin
            if (key == '0) begin
                e_err = 1; e_lat = 1;
            end else begin
                e_rd = 1; found = -1; free = -1;
                for (int i = 0; i < DEPTH; i++) if (m_vld[i] && m_key[i] == key) found = i;
                for (int i = DEPTH - 1; i >= 0; i--) if (!m_vld[i]) free = i;
                if (found >= 0) begin
                    e_hit = 1; e_idx = 6'(found); e_lat = 2;
                end else begin
                    e_lat = 3; e_wr = 1;
                    if (free >= 0) e_idx = 6'(free);
                    else begin
                        e_idx = 6'(m_vptr); e_evict = 1; m_vptr = (m_vptr + 1) % DEPTH;
                    end
                    m_key[e_idx] = key; m_vld[e_idx] = 1'b1;
                end
            end
        end else begin
            e_wr = 1; e_idx = idx; e_hit = m_vld[idx];
            m_vld[idx] = 1'b0; m_key[idx] = '0;
        end

        @(negedge clk);
        check("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_key = key; bus.req_idx = idx;
        wr0 = wr_cnt; rd0 = rd_cnt;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 12) begin
            @(posedge clk); #1; lat++;
        end
        check("latency", lat, e_lat);
        check("rsp_err", bus.rsp_err, e_err);
        if (!e_err) begin
            check("rsp_idx", bus.rsp_idx, e_idx);
            check("rsp_hit", bus.rsp_hit, e_hit);
            check("rsp_evict", bus.rsp_evict, e_evict);
        end
        o_idx = bus.rsp_idx; o_hit = bus.rsp_hit; o_evict = bus.rsp_evict; o_err = bus.rsp_err;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            check("hold_rsp_valid", bus.rsp_valid, 1);
            check("hold_req_ready", bus.req_ready, 0);
            check("hold_err", bus.rsp_err, e_err);
            if (!e_err) check("hold_idx", {bus.rsp_idx, bus.rsp_hit, bus.rsp_evict}, {e_idx, e_hit, e_evict});
        end
        @(negedge clk); bus.rsp_ready = 1'b1;
        @(posedge clk); #1; bus.rsp_ready = 1'b0;
        check("rsp_release", bus.rsp_valid, 0);
        check("cam_writes", wr_cnt - wr0, e_wr);
        check("cam_searches", rd_cnt - rd0, e_rd);
        check("valid_vec", valid_vec, m_vld);
        check("count", count, $countones(m_vld));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ri;
        logic rh, rev, rerr;
        logic [DATA-1:0] k;
        int r, j;

        bus.req_valid = 0; bus.req_op = 0; bus.req_key = '0; bus.req_idx = '0; bus.rsp_ready = 0;
        model_reset();
        reset_ = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_fields", {bus.rsp_idx, bus.rsp_hit, bus.rsp_evict, bus.rsp_err}, 0);
        check("rst_cam_en", {bus.cam_we_, bus.cam_re_}, 2'b11);
        check("rst_cam_bus", {bus.cam_wd, bus.cam_rd, bus.cam_waddr, bus.cam_wm, bus.cam_rm}, 0);
        check("rst_valid_vec", valid_vec, 0);
        check("rst_count", count, 0);
        @(negedge clk); reset_ = 1'b1;

        // First insert, then the same key again.
        do_req(1'b0, 16'h1234, 6'd0, 0, ri, rh, rev, rerr);
        check("first_idx", ri, 0);
        check("first_count", count, 1);
        do_req(1'b0, 16'h1234, 6'd0, 0, ri, rh, rev, rerr);
        check("dup_hit", {rh, ri}, {1'b1, 6'd0});

        // Fill the table, then evict round-robin until the pointer wraps.
        for (int i = 1; i < DEPTH; i++) begin
            fresh_key(k);
            do_req(1'b0, k, 6'd0, 0, ri, rh, rev, rerr);
        end
        check("full_count", count, 64);
        do_req(1'b0, 16'hBEEF, 6'd0, 0, ri, rh, rev, rerr);
        check("beef_evict", {rev, ri}, {1'b1, 6'd0});
        fresh_key(k);
        do_req(1'b0, k, 6'd0, 0, ri, rh, rev, rerr);
        check("evict_next", {rev, ri}, {1'b1, 6'd1});
        for (int i = 0; i < 62; i++) begin
            fresh_key(k);
            do_req(1'b0, k, 6'd0, 0, ri, rh, rev, rerr);
        end
        fresh_key(k);
        do_req(1'b0, k, 6'd0, 0, ri, rh, rev, rerr);
        check("evict_wrap", {rev, ri}, {1'b1, 6'd0});

        // Delete / refill / double delete of entry 5.
        do_req(1'b1, '0, 6'd5, 0, ri, rh, rev, rerr);
        check("del5_hit", rh, 1);
        check("del5_vld", valid_vec[5], 0);
        fresh_key(k);
        do_req(1'b0, k, 6'd0, 0, ri, rh, rev, rerr);
        check("refill5", {rev, ri}, {1'b0, 6'd5});
        do_req(1'b1, '0, 6'd5, 0, ri, rh, rev, rerr);
        do_req(1'b1, '0, 6'd5, 0, ri, rh, rev, rerr);
        check("del5_again_hit", rh, 0);

        // Null key is rejected without touching the CAM.
        do_req(1'b0, 16'h0000, 6'd0, 0, ri, rh, rev, rerr);
        check("null_err", rerr, 1);

        // Response held for 10 cycles.
        fresh_key(k);
        do_req(1'b0, k, 6'd0, 10, ri, rh, rev, rerr);

        // Random mix of inserts (new, resident, null) and deletes.
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                fresh_key(k);
                do_req(1'b0, k, 6'd0, $urandom_range(0, 2), ri, rh, rev, rerr);
            end else if (r <= 4) begin
                j = $urandom_range(0, DEPTH - 1);
                if (m_vld[j]) k = m_key[j]; else fresh_key(k);
                do_req(1'b0, k, 6'd0, $urandom_range(0, 2), ri, rh, rev, rerr);
            end else if (r == 5) begin
                do_req(1'b0, 16'h0000, 6'd0, 0, ri, rh, rev, rerr);
            end else begin
                do_req(1'b1, '0, 6'($urandom_range(0, DEPTH - 1)), $urandom_range(0, 2), ri, rh, rev, rerr);
            end
        end
        j = 0;
        for (int i = 0; i < DEPTH; i++) if (cam_mem[i] !== m_key[i]) j++;
        check("cam_contents", j, 0);

        // Reset asserted while the controller is searching.
        fresh_key(k);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 1'b0; bus.req_key = k;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("in_lookup", bus.cam_re_, 0);
        reset_ = 1'b0;
        #1;
        check("midrst_rsp_valid", bus.rsp_valid, 0);
        check("midrst_valid_vec", valid_vec, 0);
        check("midrst_count", count, 0);
        check("midrst_req_ready", bus.req_ready, 1);
        model_reset();
        @(negedge clk); reset_ = 1'b1;
        do_req(1'b0, 16'h5A5A, 6'd0, 0, ri, rh, rev, rerr);
        check("post_rst_idx", {rh, rev, ri}, {1'b0, 1'b0, 6'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
